// File: rtl/wb_intercon.sv
// Single-master Wishbone interconnect: address decode to four slaves, one
// outstanding transaction, one-cycle registered response, and a BUSY timeout.
module wb_intercon #(
    parameter logic [63:0] S0_BASE        = 64'h0,
    parameter logic [63:0] S1_BASE        = 64'h1_0000_0000,
    parameter logic [63:0] S2_BASE        = 64'h1_0000_1000,
    parameter logic [63:0] S3_BASE        = 64'h1_0000_2000,
    parameter logic [63:0] S0_MASK        = 64'hFFFF_FFFF_F000_0000,
    parameter logic [63:0] S1_MASK        = 64'hFFFF_FFFF_FFFF_F000,
    parameter logic [63:0] S2_MASK        = 64'hFFFF_FFFF_FFFF_F000,
    parameter logic [63:0] S3_MASK        = 64'hFFFF_FFFF_FFFF_F000,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [63:0]   i_wb_adr,
    input  logic [63:0]   i_wb_dat,
    output logic [63:0]   o_wb_dat,
    input  logic          i_wb_we,
    input  logic [7:0]    i_wb_sel,
    input  logic          i_wb_stb,
    input  logic          i_wb_cyc,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic          o_wb_stall,
    output logic [63:0]   o_s_adr,
    output logic [63:0]   o_s_dat,
    output logic          o_s_we,
    output logic [7:0]    o_s_sel,
    output logic [3:0]    o_s_cyc,
    output logic [3:0]    o_s_stb,
    input  logic [3:0]    i_s_ack,
    input  logic [3:0]    i_s_stall,
    input  logic [255:0]  i_s_dat
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0][63:0] BASES = {S3_BASE, S2_BASE, S1_BASE, S0_BASE};
    localparam logic [3:0][63:0] MASKS = {S3_MASK, S2_MASK, S1_MASK, S0_MASK};

    logic [1:0]  state_reg, state_next;
    logic [1:0]  sel_reg, sel_next;
    logic        we_reg, we_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        ack_reg, ack_next;
    logic        err_reg, err_next;
    logic [63:0] dat_reg, dat_next;

    logic [3:0]  hit;
    logic [63:0] s_dat_arr [4];
    logic [1:0]  hit_idx;
    logic        any_hit;
    logic        req;
    logic        accept;
    logic        sel_ack;
    logic        timeout_hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slave
            assign hit[gi]       = (i_wb_adr & MASKS[gi]) == BASES[gi];
            assign s_dat_arr[gi] = i_s_dat[64*gi +: 64];
        end
    endgenerate

    // Lowest-numbered matching slave wins when windows overlap.
    always_comb begin
        hit_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) hit_idx = 2'(k);
        end
    end

    assign any_hit     = |hit;
    assign req         = i_wb_cyc & i_wb_stb;
    assign accept      = req & ~o_wb_stall;
    assign sel_ack     = i_s_ack[sel_reg];
    assign timeout_hit = ({1'b0, cnt_reg} + 17'd1) >= 17'(TIMEOUT_CYCLES);

    assign o_s_adr  = i_wb_adr;
    assign o_s_dat  = i_wb_dat;
    assign o_s_we   = i_wb_we;
    assign o_s_sel  = i_wb_sel;
    assign o_wb_dat = dat_reg;
    assign o_wb_ack = ack_reg;
    assign o_wb_err = err_reg;

    always_comb begin
        o_wb_stall = 1'b1;
        if (!i_reset && state_reg == ST_IDLE)
            o_wb_stall = any_hit ? i_s_stall[hit_idx] : 1'b0;
    end

    always_comb begin
        o_s_cyc = '0;
        o_s_stb = '0;
        if (!i_reset) begin
            case (state_reg)
                ST_IDLE: if (any_hit) begin
                    o_s_cyc[hit_idx] = req;
                    o_s_stb[hit_idx] = req;
                end
                ST_BUSY: o_s_cyc[sel_reg] = i_wb_cyc;
                default: ;
            endcase
        end
    end

    // Master abort outranks a coincident ack; ack outranks timeout.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        we_next    = we_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        dat_next   = dat_reg;
        case (state_reg)
            ST_IDLE: if (accept) begin
                if (any_hit) begin
                    state_next = ST_BUSY;
                    sel_next   = hit_idx;
                    we_next    = i_wb_we;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_RESP;
                    err_next   = 1'b1;
                    dat_next   = '0;
                end
            end
            ST_BUSY: begin
                if (!i_wb_cyc) begin
                    state_next = ST_IDLE;
                end else if (sel_ack) begin
                    state_next = ST_RESP;
                    ack_next   = 1'b1;
                    dat_next   = we_reg ? 64'h0 : s_dat_arr[sel_reg];
                end else if (timeout_hit) begin
                    state_next = ST_RESP;
                    err_next   = 1'b1;
                    dat_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            dat_reg   <= dat_next;
        end
    end

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon built with an 8-cycle timeout.
module tb_wb_intercon;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   wb_adr, wb_dat_w, wb_dat_r;
    logic          wb_we, wb_stb, wb_cyc;
    logic [7:0]    wb_sel;
    logic          wb_ack, wb_err, wb_stall;
    logic [63:0]   s_adr, s_dat_w;
    logic          s_we;
    logic [7:0]    s_sel;
    logic [3:0]    s_cyc, s_stb, s_ack, s_stall;
    logic [255:0]  s_dat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_intercon #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat_w), .o_wb_dat(wb_dat_r),
        .i_wb_we(wb_we), .i_wb_sel(wb_sel), .i_wb_stb(wb_stb), .i_wb_cyc(wb_cyc),
        .o_wb_ack(wb_ack), .o_wb_err(wb_err), .o_wb_stall(wb_stall),
        .o_s_adr(s_adr), .o_s_dat(s_dat_w), .o_s_we(s_we), .o_s_sel(s_sel),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb),
        .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_dat(s_dat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; wb_adr = '0; wb_dat_w = 64'h1234; wb_we = 1'b0; wb_sel = 8'hFF;
        wb_stb = 1'b0; wb_cyc = 1'b0; s_ack = '0; s_stall = '0;
        s_dat = '0;
        s_dat[0 +: 64]   = 64'h0000_0000_0000_AAAA;
        s_dat[64 +: 64]  = 64'h1111_2222_3333_4444;
        s_dat[128 +: 64] = 64'h0000_0000_DEAD_BEEF;
        s_dat[192 +: 64] = 64'h5555_6666_7777_8888;

        // Reset state; a request presented during reset must not reach a slave
        tick(); tick();
        wb_adr = 64'h100; wb_cyc = 1'b1; wb_stb = 1'b1;
        #1;
        chk("rst_ack", 64'(wb_ack), 64'h0);
        chk("rst_err", 64'(wb_err), 64'h0);
        chk("rst_dat", wb_dat_r, 64'h0);
        chk("rst_stall", 64'(wb_stall), 64'h1);
        chk("rst_scyc", 64'(s_cyc), 64'h0);
        chk("pass_adr", s_adr, 64'h100);
        chk("pass_dat", s_dat_w, 64'h1234);
        tick();
        reset = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;

        // Read slave 2, ack three cycles after accept
        tick();
        wb_adr = 64'h1_0000_1008; wb_cyc = 1'b1; wb_stb = 1'b1; #1;
        chk("rd2_scyc", 64'(s_cyc), 64'h4);
        chk("rd2_sstb", 64'(s_stb), 64'h4);
        chk("rd2_stall_idle", 64'(wb_stall), 64'h0);
        tick(); wb_stb = 1'b0; #1;
        chk("rd2_busy_scyc", 64'(s_cyc), 64'h4);
        chk("rd2_busy_sstb", 64'(s_stb), 64'h0);
        chk("rd2_busy_stall", 64'(wb_stall), 64'h1);
        tick();
        tick(); s_ack = 4'b0100; #1;
        chk("rd2_noack_yet", 64'(wb_ack), 64'h0);
        tick(); s_ack = '0; #1;
        chk("rd2_ack", 64'(wb_ack), 64'h1);
        chk("rd2_err", 64'(wb_err), 64'h0);
        chk("rd2_dat", wb_dat_r, 64'hDEAD_BEEF);
        chk("rd2_resp_scyc", 64'(s_cyc), 64'h0);
        tick(); wb_cyc = 1'b0; #1;
        chk("rd2_ack_done", 64'(wb_ack), 64'h0);
        chk("rd2_dat_hold", wb_dat_r, 64'hDEAD_BEEF);

        // Unmapped access
        wb_adr = 64'h2_0000_0000; wb_cyc = 1'b1; wb_stb = 1'b1; #1;
        chk("um_scyc", 64'(s_cyc), 64'h0);
        chk("um_stall", 64'(wb_stall), 64'h0);
        tick(); wb_stb = 1'b0; #1;
        chk("um_err", 64'(wb_err), 64'h1);
        chk("um_ack", 64'(wb_ack), 64'h0);
        chk("um_dat", wb_dat_r, 64'h0);
        tick(); wb_cyc = 1'b0; #1;
        chk("um_err_done", 64'(wb_err), 64'h0);

        // Timeout on slave 1, with a stray slave-0 ack along the way
        wb_adr = 64'h1_0000_0000; wb_cyc = 1'b1; wb_stb = 1'b1; #1;
        chk("to_scyc", 64'(s_cyc), 64'h2);
        tick(); wb_stb = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_ack = (i == 3) ? 4'b0001 : 4'b0000;
            #1;
            chk($sformatf("to_busy%0d_scyc", i), 64'(s_cyc), 64'h2);
            chk($sformatf("to_busy%0d_resp", i), {62'h0, wb_ack, wb_err}, 64'h0);
            tick();
        end
        s_ack = '0; #1;
        chk("to_err", 64'(wb_err), 64'h1);
        chk("to_ack", 64'(wb_ack), 64'h0);
        chk("to_scyc_drop", 64'(s_cyc), 64'h0);
        tick(); wb_cyc = 1'b0; #1;
        chk("to_err_done", 64'(wb_err), 64'h0);

        // Ack coincident with the timeout cycle: ack wins
        wb_adr = 64'h1_0000_0010; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick(); wb_stb = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        s_ack = 4'b0010;
        tick(); s_ack = '0; #1;
        chk("co_ack", 64'(wb_ack), 64'h1);
        chk("co_err", 64'(wb_err), 64'h0);
        chk("co_dat", wb_dat_r, 64'h1111_2222_3333_4444);
        tick(); wb_cyc = 1'b0;

        // Slave 3 stalls for five cycles, then a write is accepted once
        wb_adr = 64'h1_0000_2000; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1; s_stall = 4'b1000;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("st%0d_stall", i), 64'(wb_stall), 64'h1);
            chk($sformatf("st%0d_sstb", i), 64'(s_stb), 64'h8);
            tick();
        end
        s_stall = '0; #1;
        chk("st_stall_drop", 64'(wb_stall), 64'h0);
        chk("st_sstb_accept", 64'(s_stb), 64'h8);
        tick(); wb_stb = 1'b0; #1;
        chk("st_busy_sstb", 64'(s_stb), 64'h0);
        chk("st_busy_scyc", 64'(s_cyc), 64'h8);
        s_ack = 4'b1000;
        tick(); s_ack = '0; #1;
        chk("wr_ack", 64'(wb_ack), 64'h1);
        chk("wr_dat_zero", wb_dat_r, 64'h0);
        tick(); wb_cyc = 1'b0; wb_we = 1'b0; #1;
        chk("wr_ack_done", 64'(wb_ack), 64'h0);

        // Master drops cyc in BUSY while the slave acks
        wb_adr = 64'h1_0000_1000; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick(); wb_stb = 1'b0; wb_cyc = 1'b0; s_ack = 4'b0100; #1;
        chk("ab_scyc", 64'(s_cyc), 64'h0);
        tick(); s_ack = '0; #1;
        chk("ab_resp", {62'h0, wb_ack, wb_err}, 64'h0);
        chk("ab_dat", wb_dat_r, 64'h0);
        wb_cyc = 1'b1; wb_stb = 1'b1; #1;
        chk("ab_idle_sstb", 64'(s_stb), 64'h4);

        // Reset mid-BUSY with a coincident slave ack
        tick(); wb_stb = 1'b0; reset = 1'b1; s_ack = 4'b0100; #1;
        chk("rb_scyc", 64'(s_cyc), 64'h0);
        chk("rb_stall", 64'(wb_stall), 64'h1);
        tick(); reset = 1'b0; s_ack = '0; wb_cyc = 1'b0; #1;
        chk("rb_resp", {62'h0, wb_ack, wb_err}, 64'h0);
        chk("rb_dat", wb_dat_r, 64'h0);
        wb_adr = 64'h100; wb_cyc = 1'b1; wb_stb = 1'b1; #1;
        chk("rb_idle_sstb", 64'(s_stb), 64'h1);
        chk("rb_idle_stall", 64'(wb_stall), 64'h0);
        tick(); wb_cyc = 1'b0; wb_stb = 1'b0;
        tick(); tick(); #1;
        chk("end_resp", {62'h0, wb_ack, wb_err}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_intercon.md
WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 S0_BASE..S3_BASE, defaults 64'h0 / 64'h1_0000_0000 / 64'h1_0000_1000 / 64'h1_0000_2000, slave base addresses.
REQ-002 S0_MASK..S3_MASK, defaults 64'hFFFF_FFFF_F000_0000 / 64'hFFFF_FFFF_FFFF_F000 (S1..S3), address compare masks.
REQ-003 TIMEOUT_CYCLES, default 1023, max BUSY cycles before error; legal range 1..65535.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_wb_adr  in  64  master address.
REQ-007 i_wb_dat  in  64  master write data.
REQ-008 o_wb_dat  out  64  registered read data to master.
REQ-009 i_wb_we / i_wb_sel / i_wb_stb / i_wb_cyc  in  1/8/1/1  master write enable, byte select, strobe, cycle.
REQ-010 o_wb_ack / o_wb_err / o_wb_stall  out  1  master ack, error, stall.
REQ-011 o_s_adr / o_s_dat / o_s_we / o_s_sel  out  64/64/1/8  combinational copies of i_wb_adr/i_wb_dat/i_wb_we/i_wb_sel, shared by all slaves.
REQ-012 o_s_cyc / o_s_stb  out  4/4  per-slave cycle and strobe, bit k = slave k.
REQ-013 i_s_ack / i_s_stall  in  4/4  per-slave ack and stall.
REQ-014 i_s_dat  in  256  slave read data, slave k on bits [64k+63:64k].

Function
REQ-015 Hit for slave k: (i_wb_adr & Sk_MASK) == Sk_BASE; multiple hits resolve to lowest k; no hit = unmapped.
REQ-016 States IDLE, BUSY, RESP; one transaction outstanding at a time.
REQ-017 IDLE: o_wb_stall = i_s_stall[k] for hit slave k, 0 if unmapped; o_s_cyc[k] = o_s_stb[k] = i_wb_cyc & i_wb_stb for hit k only; all other bits 0.
REQ-018 Acceptance: IDLE with i_wb_cyc & i_wb_stb & ~o_wb_stall; mapped -> latch k, latch we, clear timeout counter, enter BUSY; unmapped -> enter RESP with error flag set.
REQ-019 BUSY: o_wb_stall = 1; o_s_stb = 0; o_s_cyc[k] = i_wb_cyc; other o_s_cyc bits 0.
REQ-020 BUSY with i_s_ack[k]: capture i_s_dat slice k (write transactions capture 64'h0), enter RESP with error flag clear.
REQ-021 RESP, exactly one cycle: o_wb_ack = ~errflag, o_wb_err = errflag, o_wb_stall = 1, all o_s_cyc/o_s_stb = 0; next state IDLE.
REQ-022 Latency: slave ack in cycle N -> o_wb_ack in cycle N+1; unmapped accepted in N -> o_wb_err in N+1.
REQ-023 o_wb_dat holds last captured value until next capture; error responses load 64'h0.
REQ-024 Timeout: counter increments each BUSY cycle without i_s_ack[k]; reaching TIMEOUT_CYCLES -> enter RESP with error flag, o_s_cyc[k] dropped.
REQ-025 Ack and timeout in same cycle: ack wins, normal response.
REQ-026 i_wb_cyc low in BUSY: return to IDLE next cycle, no ack/err, o_s_cyc dropped; a coincident slave ack is discarded.
REQ-027 i_wb_cyc low in RESP: RESP pulse still issued (master ignores it), then IDLE.
REQ-028 i_s_ack bits of non-selected slaves, and any i_s_ack in IDLE/RESP, are ignored.
REQ-029 o_wb_ack and o_wb_err never both 1; each high at most one cycle per accepted transaction.

Reset
REQ-030 i_reset high at a clock edge: state IDLE, counter 0, error flag 0, o_wb_dat 64'h0, o_wb_ack 0, o_wb_err 0 from that edge.
REQ-031 Reset mid-BUSY or mid-RESP: transaction dropped, no ack/err issued, o_s_cyc/o_s_stb all 0 while reset is high.
REQ-032 While reset high, o_wb_stall = 1 and no transaction is accepted.

Verification
REQ-033 Read adr 64'h1_0000_1008, slave 2 acks 3 cycles after accept with data 64'hDEAD_BEEF -> o_s_cyc=4'b0100, o_wb_ack one cycle after slave ack, o_wb_dat=64'hDEAD_BEEF.
REQ-034 Access adr 64'h2_0000_0000 (unmapped) -> no o_s_cyc bit set, o_wb_err high exactly one cycle after accept, o_wb_dat=0.
REQ-035 TIMEOUT_CYCLES=8, slave 1 never acks -> o_wb_err after 8 BUSY cycles, o_s_cyc[1] low the following cycle.
REQ-036 Slave 3 holds i_s_stall=1 for 5 cycles with stb high -> o_wb_stall high those 5 cycles, single o_s_stb pulse accepted when stall drops.
REQ-037 i_wb_cyc dropped in BUSY with slave ack same cycle; reset asserted mid-BUSY -> no o_wb_ack in either case, state IDLE.
REQ-038 Slave 0 ack while slave 1 selected, plus ack and timeout coincident -> stray ack ignored, coincident case returns o_wb_ack not o_wb_err.
